// File: rtl/mips_mem_pkg.sv
// Shared encodings, request payload and address helpers for the MEM/WB stage.
// MEM_MISALIGN_TRAP_EN (used by mem_wb_stage) selects trap vs. silent realignment.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Latched copy of the EXE/MEM request held across the memory wait states
  typedef struct packed {
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] alu;
    logic [31:0] store_data;
    logic [4:0]  dest;
  } mem_req_t;

  // Clear the low address bits that a naturally aligned access of this size ignores
  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] res;
    res = addr;
    case (size)
      SZ_BYTE: res = addr;
      SZ_HALF: res = {addr[31:1], 1'b0};
      default: res = {addr[31:2], 2'b00};
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    logic res;
    res = 1'b0;
    case (size)
      SZ_BYTE: res = 1'b0;
      SZ_HALF: res = off[0];
      default: res = (off != 2'b00);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// EXE/MEM request and MEM/WB write-back bundle between the pipeline and the MEM stage.
interface mem_wb_stage_if;

  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic [1:0]  ex_size;
  logic        ex_signed;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest_reg;

  logic        stall;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        misalign_exc;

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
           ex_size, ex_signed, ex_alu_result, ex_store_data, ex_dest_reg,
    input  stall, wb_valid, wb_reg_write, wb_dest, wb_data, misalign_exc
  );

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
           ex_size, ex_signed, ex_alu_result, ex_store_data, ex_dest_reg,
    output stall, wb_valid, wb_reg_write, wb_dest, wb_data, misalign_exc
  );

endinterface

// File: rtl/load_align.sv
// Load lane extraction: picks the addressed byte/half of a little-endian word
// and sign- or zero-extends it to 32 bits.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{off_i, 3'b000} +: 8];
    half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = word_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & byte_v[7]}}, byte_v};
      SZ_HALF: data_o = {{16{signed_i & half_v[15]}}, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM-stage data-memory responder with wait states plus MEM/WB pipeline register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of realigning them.
module mem_wb_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_wb_stage_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, req_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [4:0]        wb_dest_q, wb_dest_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              exc_q, exc_d;

  logic              stall_c;
  logic              mem_we_c;
  logic              is_mem_c;
  logic              misalign_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       rd_word_c;
  logic [31:0]       ld_data_c;
  logic [IDX_W-1:0]  idx_c;
  logic              unused_addr;

  logic [31:0] mem_q [DEPTH];

  assign is_mem_c    = bus.ex_mem_read | bus.ex_mem_write;
  assign idx_c       = req_q.addr[IDX_W+1:2];
  assign rd_word_c   = mem_q[idx_c];
  assign unused_addr = ^req_q.addr[31:IDX_W+2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_c       = is_mem_c & is_misaligned(bus.ex_alu_result[1:0], bus.ex_size);
  assign bus.misalign_exc = exc_q;
`else
  logic unused_exc;
  assign misalign_c       = 1'b0;
  assign bus.misalign_exc = 1'b0;
  assign unused_exc       = exc_q;
`endif

  load_align u_load_align (
    .word_i   (rd_word_c),
    .off_i    (req_q.addr[1:0]),
    .size_i   (req_q.size),
    .signed_i (req_q.sgn),
    .data_o   (ld_data_c)
  );

  // Store byte enables and lane-replicated write data
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = req_q.store_data;
    case (req_q.size)
      SZ_BYTE: begin
        be_c    = 4'b0001 << req_q.addr[1:0];
        wdata_c = {4{req_q.store_data[7:0]}};
      end
      SZ_HALF: begin
        be_c    = req_q.addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_q.store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Next-state and write-back logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_d          = req_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = 1'b0;
    wb_dest_d      = wb_dest_q;
    wb_data_d      = wb_data_q;
    exc_d          = 1'b0;
    stall_c        = 1'b0;
    mem_we_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ex_valid) begin
          if (misalign_c) begin
            wb_valid_d = 1'b1;
            exc_d      = 1'b1;
            wb_dest_d  = bus.ex_dest_reg;
            wb_data_d  = bus.ex_alu_result;
          end else if (is_mem_c) begin
            stall_c          = 1'b1;
            state_d          = ST_BUSY;
            cnt_d            = CNT_INIT;
            req_d.mem_write  = bus.ex_mem_write;
            req_d.reg_write  = bus.ex_reg_write;
            req_d.mem_to_reg = bus.ex_mem_to_reg;
            req_d.size       = bus.ex_size;
            req_d.sgn        = bus.ex_signed;
            req_d.addr       = align_addr(bus.ex_alu_result, bus.ex_size);
            req_d.alu        = bus.ex_alu_result;
            req_d.store_data = bus.ex_store_data;
            req_d.dest       = bus.ex_dest_reg;
          end else begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = bus.ex_reg_write & (bus.ex_dest_reg != 5'd0);
            wb_dest_d      = bus.ex_dest_reg;
            wb_data_d      = bus.ex_alu_result;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          state_d        = ST_IDLE;
          mem_we_c       = req_q.mem_write;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = req_q.reg_write & ~req_q.mem_write & (req_q.dest != 5'd0);
          wb_dest_d      = req_q.dest;
          wb_data_d      = req_q.mem_to_reg ? ld_data_c : req_q.alu;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      req_q          <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_dest_q      <= '0;
      wb_data_q      <= '0;
      exc_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_q          <= req_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_dest_q      <= wb_dest_d;
      wb_data_q      <= wb_data_d;
      exc_q          <= exc_d;
    end
  end

  // Data memory is not reset; a reset edge suppresses any pending commit
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem_q[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
      end
    end
  end

  assign bus.stall        = stall_c;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_reg_write = wb_reg_write_q;
  assign bus.wb_dest      = wb_dest_q;
  assign bus.wb_data      = wb_data_q;

endmodule
